fb_mem_ctrl: RTL



---
 rtl/fb_mem_ctrl_pkg.sv | 36 +++
 rtl/fb_mem_ctrl_ram.sv | 45 ++++
 rtl/fb_mem_ctrl.sv | 189 ++++++++++++++++++
 3 files changed

// File: rtl/fb_mem_ctrl_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : fb_mem_ctrl_pkg                                                  |
// | Purpose : Shared constants for the framebuffer memory controller: control  |
// |           bus field positions, the FSM state encoding and a small helper.  |
// | Rev     : 1.0  initial release                                             |
// +----------------------------------------------------------------------------+
package fb_mem_ctrl_pkg;

    // ctrl_in / ctrl_out field positions
    localparam int CTRL_WR_BIT    = 7;
    localparam int CTRL_BURST_MSB = 2;
    localparam int CTRL_BURST_LSB = 0;
    localparam int CTRL_WAIT_BIT  = 0;

    localparam int BURST_W = CTRL_BURST_MSB - CTRL_BURST_LSB + 1;

    // FSM state encoding
    localparam int STATE_W = 3;
    typedef logic [STATE_W-1:0] state_t;

    localparam state_t ST_IDLE     = 3'd0;
    localparam state_t ST_ACK      = 3'd1;
    localparam state_t ST_RD_ADDR  = 3'd2;
    localparam state_t ST_RD_STALL = 3'd3;
    localparam state_t ST_RD_DATA  = 3'd4;
    localparam state_t ST_WR_DATA  = 3'd5;
    localparam state_t ST_DONE     = 3'd6;

    // Wait flag presented to the master while the FSM sits in a given state.
    function automatic logic state_waits(input state_t s);
        return (s == ST_ACK) || (s == ST_RD_ADDR) || (s == ST_RD_STALL) || (s == ST_DONE);
    endfunction

endpackage
`default_nettype wire

// File: rtl/fb_mem_ctrl_ram.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : fb_ram                                                           |
// | Purpose : Single-port framebuffer RAM, 16-bit words, depth 2**ADDR_W.      |
// |           Synchronous write; synchronous read whose output register only   |
// |           updates when i_re is high, so read data is held across stalls.   |
// | Ports   : clk      - clock                                                 |
// |           i_we     - write enable (writes i_wdata to i_addr)               |
// |           i_re     - read enable (loads o_rdata from i_addr)               |
// |           i_addr   - word address                                          |
// |           i_wdata  - write data                                            |
// |           o_rdata  - registered read data                                  |
// | Rev     : 1.0  initial release                                             |
// +----------------------------------------------------------------------------+
module fb_ram #(
    parameter int ADDR_W = 15,
    parameter int DATA_W = 16
) (
    input  logic              clk,
    input  logic              i_we,
    input  logic              i_re,
    input  logic [ADDR_W-1:0] i_addr,
    input  logic [DATA_W-1:0] i_wdata,
    output logic [DATA_W-1:0] o_rdata
);

    localparam int c_DEPTH = 1 << ADDR_W;

    // No reset on the array: framebuffer contents survive controller reset.
    logic [DATA_W-1:0] r_mem [c_DEPTH];
    logic [DATA_W-1:0] r_rdata;

    always_ff @(posedge clk) begin
        if (i_we) begin
            r_mem[i_addr] <= i_wdata;
        end
        if (i_re) begin
            r_rdata <= r_mem[i_addr];
        end
    end

    assign o_rdata = r_rdata;

endmodule
`default_nettype wire

// File: rtl/fb_mem_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : fb_mem_ctrl                                                      |
// | Purpose : Bus-slave controller for a 16-bit framebuffer RAM. A master      |
// |           raises bus_req, receives a one-cycle bus_ack during which the    |
// |           address and control word are captured, then transfers a burst   |
// |           of 1..8 words. Reads take 2+WAIT_STATES cycles per beat; writes  |
// |           take one cycle per beat. Addresses wrap modulo 2**ADDR_W.        |
// | Ports   : clk      - clock                                                 |
// |           reset    - synchronous active-high reset                         |
// |           bus_req  - transfer request (sampled in IDLE only)               |
// |           bus_in   - address in the ACK cycle, write data in [15:0]        |
// |           ctrl_in  - [7] write, [2:0] burst length minus one              |
// |           bus_ack  - one-cycle grant                                      |
// |           ctrl_out - [0] wait, all other bits zero                         |
// |           bus_out  - read data in [15:0], upper bits zero                  |
// | Rev     : 1.0  initial release                                             |
// +----------------------------------------------------------------------------+
module fb_mem_ctrl
    import fb_mem_ctrl_pkg::*;
#(
    parameter int BUS_WIDTH   = 32,
    parameter int CTRL_WIDTH  = 8,
    parameter int ADDR_W      = 15,
    parameter int WAIT_STATES = 0
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  bus_req,
    input  logic [BUS_WIDTH-1:0]  bus_in,
    input  logic [CTRL_WIDTH-1:0] ctrl_in,
    output logic                  bus_ack,
    output logic [CTRL_WIDTH-1:0] ctrl_out,
    output logic [BUS_WIDTH-1:0]  bus_out
);

    localparam int c_DATA_W  = 16;
    localparam int c_STALL_W = (WAIT_STATES > 1) ? $clog2(WAIT_STATES) : 1;
    localparam logic [c_STALL_W-1:0] c_STALL_INIT =
        c_STALL_W'((WAIT_STATES > 0) ? (WAIT_STATES - 1) : 0);

    state_t               r_state;
    logic                 r_ack;
    logic                 r_wait;
    logic [ADDR_W-1:0]    r_addr;
    logic [BURST_W-1:0]   r_beat_cnt;   // beats remaining after the current one
    logic [c_STALL_W-1:0] r_stall_cnt;  // stall cycles remaining after the current one
    logic [c_DATA_W-1:0]  r_rd_hold;    // last delivered read word

    logic                 w_ram_we;
    logic                 w_ram_re;
    logic [c_DATA_W-1:0]  w_ram_rdata;
    logic [c_DATA_W-1:0]  w_rd_data;
    logic [CTRL_WIDTH-1:0] w_ctrl;
    logic                 w_unused_bits;

    // ------------------------------------------------------------------------
    // RAM
    // ------------------------------------------------------------------------
    // A reset arriving during a write beat must not commit that beat.
    assign w_ram_we = (r_state == ST_WR_DATA) && !reset;
    assign w_ram_re = (r_state == ST_RD_ADDR);

    fb_ram #(
        .ADDR_W (ADDR_W),
        .DATA_W (c_DATA_W)
    ) u_ram (
        .clk     (clk),
        .i_we    (w_ram_we),
        .i_re    (w_ram_re),
        .i_addr  (r_addr),
        .i_wdata (bus_in[c_DATA_W-1:0]),
        .o_rdata (w_ram_rdata)
    );

    // ------------------------------------------------------------------------
    // Control FSM; bus_ack and wait are registered alongside the state so
    // they always describe the state being entered.
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= ST_IDLE;
            r_ack       <= 1'b0;
            r_wait      <= 1'b0;
            r_addr      <= '0;
            r_beat_cnt  <= '0;
            r_stall_cnt <= '0;
            r_rd_hold   <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (bus_req) begin
                        r_state <= ST_ACK;
                        r_ack   <= 1'b1;
                        r_wait  <= state_waits(ST_ACK);
                    end
                end

                ST_ACK: begin
                    r_ack      <= 1'b0;
                    r_addr     <= bus_in[ADDR_W-1:0];
                    r_beat_cnt <= ctrl_in[CTRL_BURST_MSB:CTRL_BURST_LSB];
                    if (ctrl_in[CTRL_WR_BIT]) begin
                        r_state <= ST_WR_DATA;
                        r_wait  <= state_waits(ST_WR_DATA);
                    end else begin
                        r_state <= ST_RD_ADDR;
                        r_wait  <= state_waits(ST_RD_ADDR);
                    end
                end

                ST_RD_ADDR: begin
                    if (WAIT_STATES > 0) begin
                        r_state     <= ST_RD_STALL;
                        r_stall_cnt <= c_STALL_INIT;
                        r_wait      <= state_waits(ST_RD_STALL);
                    end else begin
                        r_state <= ST_RD_DATA;
                        r_wait  <= state_waits(ST_RD_DATA);
                    end
                end

                ST_RD_STALL: begin
                    if (r_stall_cnt == '0) begin
                        r_state <= ST_RD_DATA;
                        r_wait  <= state_waits(ST_RD_DATA);
                    end else begin
                        r_stall_cnt <= r_stall_cnt - 1'b1;
                    end
                end

                ST_RD_DATA: begin
                    r_rd_hold <= w_ram_rdata;
                    r_addr    <= r_addr + 1'b1;   // wraps modulo 2**ADDR_W
                    if (r_beat_cnt == '0) begin
                        r_state <= ST_DONE;
                        r_wait  <= state_waits(ST_DONE);
                    end else begin
                        r_beat_cnt <= r_beat_cnt - 1'b1;
                        r_state    <= ST_RD_ADDR;
                        r_wait     <= state_waits(ST_RD_ADDR);
                    end
                end

                ST_WR_DATA: begin
                    r_addr <= r_addr + 1'b1;
                    if (r_beat_cnt == '0) begin
                        r_state <= ST_DONE;
                        r_wait  <= state_waits(ST_DONE);
                    end else begin
                        r_beat_cnt <= r_beat_cnt - 1'b1;
                    end
                end

                ST_DONE: begin
                    r_state <= ST_IDLE;
                    r_wait  <= state_waits(ST_IDLE);
                end

                default: begin
                    r_state <= ST_IDLE;
                    r_ack   <= 1'b0;
                    r_wait  <= 1'b0;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------------
    // The RAM output register is only valid for the beat in RD_DATA; outside
    // it the last delivered word is presented instead.
    assign w_rd_data = (r_state == ST_RD_DATA) ? w_ram_rdata : r_rd_hold;

    always_comb begin
        w_ctrl                = '0;
        w_ctrl[CTRL_WAIT_BIT] = r_wait;
    end

    assign bus_ack  = r_ack;
    assign ctrl_out = w_ctrl;
    assign bus_out  = {{(BUS_WIDTH - c_DATA_W){1'b0}}, w_rd_data};

    // Address bits above ADDR_W and reserved control bits are intentionally ignored.
    assign w_unused_bits = ^{bus_in, ctrl_in};

endmodule
`default_nettype wire
